// File: rtl/axi_rd_arb.sv
// axi_rd_arb: shares one AXI4 read master (AR + R) between a feature fetch
// engine (requester 0) and a weight fetch engine (requester 1).
// Grants bursts round-robin into a single AR output slot, tags them with ARID,
// counts outstanding bursts per requester and steers R beats back by RID.
// Optional macro AXI_RD_WT_PRIO_EN: requester 1 wins every tie (fixed priority).
module axi_rd_arb #(
  parameter int unsigned ID_W     = 4,
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned MAX_OUTS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_ar_vld,
  output logic              req0_ar_rdy,
  input  logic [31:0]       req0_ar_addr,
  input  logic [7:0]        req0_ar_len,
  output logic              req0_r_vld,
  output logic [DATA_W-1:0] req0_r_data,
  output logic              req0_r_last,
  input  logic              req0_r_rdy,
  input  logic              req1_ar_vld,
  output logic              req1_ar_rdy,
  input  logic [31:0]       req1_ar_addr,
  input  logic [7:0]        req1_ar_len,
  output logic              req1_r_vld,
  output logic [DATA_W-1:0] req1_r_data,
  output logic              req1_r_last,
  input  logic              req1_r_rdy,
  output logic [31:0]       M_AXI_ARADDR,
  output logic [7:0]        M_AXI_ARLEN,
  output logic [ID_W-1:0]   M_AXI_ARID,
  output logic [2:0]        M_AXI_ARSIZE,
  output logic [1:0]        M_AXI_ARBURST,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  input  logic [ID_W-1:0]   M_AXI_RID,
  input  logic [DATA_W-1:0] M_AXI_RDATA,
  input  logic              M_AXI_RLAST,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY,
  output logic              idle,
  output logic              rid_err
);

  localparam int unsigned OUTS_W  = $clog2(MAX_OUTS + 1);
  localparam int unsigned PEND_W  = OUTS_W + 1;
  localparam logic [2:0]  AR_SIZE = 3'($clog2(DATA_W / 8));

  typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_state_t;

  slot_state_t       slot_state;
  logic [OUTS_W-1:0] outs0, outs1;
  logic [PEND_W-1:0] pend0, pend1;
  logic              slot_full, ar_drain, can_load;
  logic              slot_is0, slot_is1, rid_is0, rid_is1;
  logic              elig0, elig1, pick1, gnt0, gnt1, r_done;

  assign slot_full = (slot_state == SLOT_FULL);
  assign ar_drain  = slot_full && M_AXI_ARREADY;
  assign can_load  = !slot_full || M_AXI_ARREADY;

  // A burst parked in the slot already counts against its requester's limit
  assign slot_is0 = slot_full && (M_AXI_ARID == ID_W'(0));
  assign slot_is1 = slot_full && (M_AXI_ARID == ID_W'(1));
  assign pend0    = PEND_W'(outs0) + PEND_W'(slot_is0);
  assign pend1    = PEND_W'(outs1) + PEND_W'(slot_is1);
  assign elig0    = req0_ar_vld && (pend0 < PEND_W'(MAX_OUTS));
  assign elig1    = req1_ar_vld && (pend1 < PEND_W'(MAX_OUTS));

`ifdef AXI_RD_WT_PRIO_EN
  assign pick1 = 1'b1;
`else
  logic rr_ptr;

  // Tie-break pointer: names the requester favoured next, flips after each grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rr_ptr <= 1'b0;
    else if (gnt0) rr_ptr <= 1'b1;
    else if (gnt1) rr_ptr <= 1'b0;
  end

  assign pick1 = rr_ptr;
`endif

  assign gnt0        = can_load && elig0 && !(elig1 && pick1);
  assign gnt1        = can_load && elig1 && !(elig0 && !pick1);
  assign req0_ar_rdy = gnt0;
  assign req1_ar_rdy = gnt1;

  // AR output slot: load on grant (also while draining), empty on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_state   <= SLOT_EMPTY;
      M_AXI_ARADDR <= 32'd0;
      M_AXI_ARLEN  <= 8'd0;
      M_AXI_ARID   <= '0;
    end else if (gnt0 || gnt1) begin
      slot_state   <= SLOT_FULL;
      M_AXI_ARADDR <= gnt1 ? req1_ar_addr : req0_ar_addr;
      M_AXI_ARLEN  <= gnt1 ? req1_ar_len : req0_ar_len;
      M_AXI_ARID   <= ID_W'(gnt1);
    end else if (ar_drain) begin
      slot_state   <= SLOT_EMPTY;
    end
  end

  assign M_AXI_ARVALID = slot_full;
  assign M_AXI_ARSIZE  = AR_SIZE;
  assign M_AXI_ARBURST = 2'b01;

  // R steering by RID; unknown IDs are always accepted and dropped
  assign rid_is0      = (M_AXI_RID == ID_W'(0));
  assign rid_is1      = (M_AXI_RID == ID_W'(1));
  assign req0_r_vld   = M_AXI_RVALID && rid_is0;
  assign req1_r_vld   = M_AXI_RVALID && rid_is1;
  assign req0_r_data  = M_AXI_RDATA;
  assign req1_r_data  = M_AXI_RDATA;
  assign req0_r_last  = M_AXI_RLAST;
  assign req1_r_last  = M_AXI_RLAST;
  assign M_AXI_RREADY = rid_is0 ? req0_r_rdy : (rid_is1 ? req1_r_rdy : 1'b1);
  assign r_done       = M_AXI_RVALID && M_AXI_RREADY && M_AXI_RLAST;

  // Outstanding burst count for requester 0; saturates at zero for stray beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outs0 <= '0;
    end else begin
      if (ar_drain && slot_is0 && !(r_done && rid_is0))
        outs0 <= outs0 + OUTS_W'(1);
      else if (r_done && rid_is0 && !(ar_drain && slot_is0) && (outs0 != '0))
        outs0 <= outs0 - OUTS_W'(1);
    end
  end

  // Outstanding burst count for requester 1; saturates at zero for stray beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outs1 <= '0;
    end else begin
      if (ar_drain && slot_is1 && !(r_done && rid_is1))
        outs1 <= outs1 + OUTS_W'(1);
      else if (r_done && rid_is1 && !(ar_drain && slot_is1) && (outs1 != '0))
        outs1 <= outs1 - OUTS_W'(1);
    end
  end

  // Sticky flag for any beat carrying an ID neither requester owns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  rid_err <= 1'b0;
    else if (M_AXI_RVALID && !rid_is0 && !rid_is1) rid_err <= 1'b1;
  end

  assign idle = !slot_full && (outs0 == '0) && (outs1 == '0) && !req0_ar_vld && !req1_ar_vld;

endmodule

// File: tb/tb_axi_rd_arb.sv
// tb_axi_rd_arb: directed table/sequence tests plus randomized traffic checked
// against a transaction-level model of the read arbiter.
module tb_axi_rd_arb;
  localparam int unsigned ID_W     = 4;
  localparam int unsigned DATA_W   = 128;
  localparam int unsigned MAX_OUTS = 4;
`ifdef AXI_RD_WT_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic req0_ar_vld, req0_ar_rdy, req0_r_vld, req0_r_last, req0_r_rdy;
  logic req1_ar_vld, req1_ar_rdy, req1_r_vld, req1_r_last, req1_r_rdy;
  logic [31:0] req0_ar_addr, req1_ar_addr, M_AXI_ARADDR;
  logic [7:0]  req0_ar_len, req1_ar_len, M_AXI_ARLEN;
  logic [DATA_W-1:0] req0_r_data, req1_r_data, M_AXI_RDATA;
  logic [ID_W-1:0] M_AXI_ARID, M_AXI_RID;
  logic [2:0] M_AXI_ARSIZE;
  logic [1:0] M_AXI_ARBURST;
  logic M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;
  logic idle, rid_err;

  always #5 clk = ~clk;

  axi_rd_arb #(.ID_W(ID_W), .DATA_W(DATA_W), .MAX_OUTS(MAX_OUTS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_ar_vld(req0_ar_vld), .req0_ar_rdy(req0_ar_rdy), .req0_ar_addr(req0_ar_addr),
    .req0_ar_len(req0_ar_len), .req0_r_vld(req0_r_vld), .req0_r_data(req0_r_data),
    .req0_r_last(req0_r_last), .req0_r_rdy(req0_r_rdy),
    .req1_ar_vld(req1_ar_vld), .req1_ar_rdy(req1_ar_rdy), .req1_ar_addr(req1_ar_addr),
    .req1_ar_len(req1_ar_len), .req1_r_vld(req1_r_vld), .req1_r_data(req1_r_data),
    .req1_r_last(req1_r_last), .req1_r_rdy(req1_r_rdy),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARID(M_AXI_ARID),
    .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RID(M_AXI_RID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RLAST(M_AXI_RLAST),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
    .idle(idle), .rid_err(rid_err)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: one pending AR slot, issued-but-unfinished burst counts
  bit          m_slot_v;
  int          m_slot_id;
  logic [31:0] m_slot_addr;
  logic [7:0]  m_slot_len;
  int          m_outs[2];
  int          m_fav;
  bit          m_rid_err;
  bit          m_g0, m_g1, m_rhs, m_drain;
  int          m_win;

  int gq[$];
  int del0, del1;
  int q0[$], q1[$];
  bit slave_en;

  typedef struct {
    logic       rvalid;
    logic [3:0] rid;
    logic       rdy0, rdy1;
    logic       ev0, ev1, err;
  } rvec_t;
  rvec_t tbl[7];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Settle combinational paths, compare every output against the model
  task automatic eval();
    bit can;
    bit el[2];
    bit vld[2];
    int pend;
    logic e_rr;
    #1;
    vld[0] = req0_ar_vld;
    vld[1] = req1_ar_vld;
    m_drain = m_slot_v && M_AXI_ARREADY;
    can = !m_slot_v || M_AXI_ARREADY;
    for (int n = 0; n < 2; n++) begin
      pend = m_outs[n] + ((m_slot_v && m_slot_id == n) ? 1 : 0);
      el[n] = vld[n] && (pend < int'(MAX_OUTS));
    end
    if (el[0] && el[1]) m_win = PRIO ? 1 : m_fav;
    else                m_win = el[1] ? 1 : 0;
    m_g0 = can && el[0] && (m_win == 0);
    m_g1 = can && el[1] && (m_win == 1);
    e_rr = (M_AXI_RID == 0) ? req0_r_rdy : ((M_AXI_RID == 1) ? req1_r_rdy : 1'b1);
    m_rhs = M_AXI_RVALID && e_rr;

    check("arvalid", M_AXI_ARVALID, m_slot_v);
    if (m_slot_v) begin
      check("araddr", M_AXI_ARADDR, m_slot_addr);
      check("arlen", M_AXI_ARLEN, m_slot_len);
      check("arid", M_AXI_ARID, m_slot_id);
    end
    check("ar_rdy0", req0_ar_rdy, m_g0);
    check("ar_rdy1", req1_ar_rdy, m_g1);
    check("r_vld0", req0_r_vld, M_AXI_RVALID && M_AXI_RID == 0);
    check("r_vld1", req1_r_vld, M_AXI_RVALID && M_AXI_RID == 1);
    check("rready", M_AXI_RREADY, e_rr);
    if (M_AXI_RVALID) begin
      check("r_data0", req0_r_data, M_AXI_RDATA);
      check("r_data1", req1_r_data, M_AXI_RDATA);
      check("r_last", {req1_r_last, req0_r_last}, {M_AXI_RLAST, M_AXI_RLAST});
    end
    check("idle", idle, !m_slot_v && m_outs[0] == 0 && m_outs[1] == 0 && !vld[0] && !vld[1]);
    check("rid_err", rid_err, m_rid_err);
    check("arsize_burst", {M_AXI_ARSIZE, M_AXI_ARBURST}, {3'd4, 2'b01});

    if (req0_ar_rdy) gq.push_back(0);
    if (req1_ar_rdy) gq.push_back(1);
    if (req0_r_vld && M_AXI_RREADY) del0++;
    if (req1_r_vld && M_AXI_RREADY) del1++;
  endtask

  // Advance the model across the clock edge
  task automatic adv();
    bit inc, dec;
    for (int n = 0; n < 2; n++) begin
      inc = m_drain && (m_slot_id == n);
      dec = m_rhs && M_AXI_RLAST && (M_AXI_RID == n);
      if (inc && !dec) m_outs[n]++;
      else if (dec && !inc && m_outs[n] > 0) m_outs[n]--;
    end
    if (slave_en && m_drain) begin
      if (m_slot_id == 0) q0.push_back(int'(m_slot_len) + 1);
      else                q1.push_back(int'(m_slot_len) + 1);
    end
    if (m_g0 || m_g1) begin
      m_slot_v    = 1'b1;
      m_slot_id   = m_win;
      m_slot_addr = m_win == 1 ? req1_ar_addr : req0_ar_addr;
      m_slot_len  = m_win == 1 ? req1_ar_len : req0_ar_len;
      m_fav       = 1 - m_win;
    end else if (m_drain) begin
      m_slot_v = 1'b0;
    end
    if (M_AXI_RVALID && M_AXI_RID > 1) m_rid_err = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    eval();
    adv();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_ar_vld = 0; req1_ar_vld = 0; req0_ar_addr = 0; req1_ar_addr = 0;
    req0_ar_len = 0; req1_ar_len = 0; req0_r_rdy = 0; req1_r_rdy = 0;
    M_AXI_ARREADY = 0; M_AXI_RID = 0; M_AXI_RDATA = 0; M_AXI_RLAST = 0; M_AXI_RVALID = 0;
    m_slot_v = 0; m_slot_id = 0; m_slot_addr = 0; m_slot_len = 0;
    m_outs[0] = 0; m_outs[1] = 0; m_fav = 0; m_rid_err = 0;
    m_g0 = 0; m_g1 = 0; m_rhs = 0; m_drain = 0;
    gq.delete(); q0.delete(); q1.delete(); del0 = 0; del1 = 0; slave_en = 0;
    #1;
    check("rst_arvalid", M_AXI_ARVALID, 1'b0);
    check("rst_araddr", M_AXI_ARADDR, 32'd0);
    check("rst_arlen", M_AXI_ARLEN, 8'd0);
    check("rst_arid", M_AXI_ARID, 4'd0);
    check("rst_ar_rdy", {req1_ar_rdy, req0_ar_rdy}, 2'b00);
    check("rst_rid_err", rid_err, 1'b0);
    check("rst_idle", idle, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bit done;
    int rid_s[6]  = '{0, 1, 1, 0, 1, 1};
    int last_s[6] = '{0, 0, 0, 1, 0, 1};
    int rdy1_s[6] = '{1, 0, 1, 1, 0, 1};

    tbl[0] = '{1'b1, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 4'd1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 4'd1,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 4'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 4'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    do_reset();

    // R routing table, ending on unknown IDs
    for (int i = 0; i < 7; i++) begin
      M_AXI_RVALID = tbl[i].rvalid; M_AXI_RID = tbl[i].rid; M_AXI_RLAST = 1'b1;
      M_AXI_RDATA = {$urandom, $urandom, $urandom, $urandom};
      req0_r_rdy = tbl[i].rdy0; req1_r_rdy = tbl[i].rdy1;
      eval();
      check("tbl_vld", {req1_r_vld, req0_r_vld}, {tbl[i].ev1, tbl[i].ev0});
      check("tbl_rready", M_AXI_RREADY, tbl[i].err);
      adv();
    end
    M_AXI_RVALID = 0; M_AXI_RID = 0;
    for (int i = 0; i < 3; i++) step();
    check("rid_err_hold", rid_err, 1'b1);
    do_reset();

    // Single 16-beat burst
    req0_ar_vld = 1; req0_ar_addr = 32'h1000; req0_ar_len = 8'd15; M_AXI_ARREADY = 1;
    eval();
    check("sb_grant", req0_ar_rdy, 1'b1);
    adv();
    req0_ar_vld = 0;
    eval();
    check("sb_ar", {M_AXI_ARVALID, M_AXI_ARID, M_AXI_ARLEN, M_AXI_ARADDR},
          {1'b1, 4'd0, 8'd15, 32'h1000});
    adv();
    req0_r_rdy = 1;
    for (int b = 0; b < 16; b++) begin
      M_AXI_RVALID = 1; M_AXI_RID = 0; M_AXI_RLAST = (b == 15);
      M_AXI_RDATA = {$urandom, $urandom, $urandom, $urandom};
      eval();
      check("sb_beat", {req0_r_vld, req0_r_last, req1_r_vld}, {1'b1, b == 15, 1'b0});
      if (b == 0) check("sb_busy", idle, 1'b0);
      adv();
    end
    M_AXI_RVALID = 0; M_AXI_RLAST = 0;
    eval();
    check("sb_idle", idle, 1'b1);
    adv();
    do_reset();

    // Contention: both requesters held valid
    req0_ar_vld = 1; req0_ar_addr = 32'hA000; req0_ar_len = 8'd3;
    req1_ar_vld = 1; req1_ar_addr = 32'hB000; req1_ar_len = 8'd7; M_AXI_ARREADY = 1;
    for (int i = 0; i < 20 && gq.size() < 4; i++) step();
    check("cont_count", gq.size(), 4);
    for (int i = 0; i < 4 && i < gq.size(); i++)
      check("cont_order", gq[i], PRIO ? 1 : (i % 2));
    do_reset();

    // AR backpressure, then reset while the slot is full
    req0_ar_vld = 1; req0_ar_addr = 32'h2000; req0_ar_len = 8'd3;
    step();
    req0_ar_vld = 0; req1_ar_vld = 1; req1_ar_addr = 32'h3000; req1_ar_len = 8'd1;
    for (int i = 0; i < 5; i++) begin
      eval();
      check("bp_hold", {M_AXI_ARVALID, M_AXI_ARID, M_AXI_ARADDR}, {1'b1, 4'd0, 32'h2000});
      check("bp_no_rdy1", req1_ar_rdy, 1'b0);
      adv();
    end
    do_reset();

    // Outstanding limit on requester 0
    req0_ar_vld = 1; req0_ar_addr = 32'h4000; req0_ar_len = 8'd0; M_AXI_ARREADY = 1;
    for (int i = 0; i < 10; i++) step();
    check("lim_count", gq.size(), 4);
    M_AXI_RVALID = 1; M_AXI_RID = 0; M_AXI_RLAST = 1; req0_r_rdy = 1;
    eval();
    check("lim_stall", req0_ar_rdy, 1'b0);
    adv();
    M_AXI_RVALID = 0;
    eval();
    check("lim_regrant", req0_ar_rdy, 1'b1);
    adv();
    do_reset();

    // Interleaved R bursts with requester 1 backpressure
    req0_ar_vld = 1; req0_ar_addr = 32'h5000; req0_ar_len = 8'd1;
    req1_ar_vld = 1; req1_ar_addr = 32'h6000; req1_ar_len = 8'd1; M_AXI_ARREADY = 1;
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      step();
      if (m_g0) req0_ar_vld = 0;
      if (m_g1) req1_ar_vld = 0;
      done = !req0_ar_vld && !req1_ar_vld && !m_slot_v;
    end
    check("ilv_issue", done, 1'b1);
    req0_r_rdy = 1;
    for (int i = 0; i < 6; i++) begin
      M_AXI_RVALID = 1; M_AXI_RID = 4'(rid_s[i]); M_AXI_RLAST = last_s[i][0];
      M_AXI_RDATA = {$urandom, $urandom, $urandom, $urandom};
      req1_r_rdy = rdy1_s[i][0];
      eval();
      check("ilv_rready", M_AXI_RREADY, rid_s[i] == 1 ? rdy1_s[i][0] : 1'b1);
      adv();
    end
    M_AXI_RVALID = 0;
    eval();
    check("ilv_delivered", {8'(del0), 8'(del1)}, {8'd2, 8'd2});
    check("ilv_idle", idle, 1'b1);
    adv();
    do_reset();

    // Randomized traffic with a responding slave
    slave_en = 1;
    for (int c = 0; c < 3000; c++) begin
      if (!req0_ar_vld || m_g0) begin
        req0_ar_vld = ($urandom_range(0, 2) == 0);
        req0_ar_addr = $urandom; req0_ar_len = 8'($urandom_range(0, 7));
      end
      if (!req1_ar_vld || m_g1) begin
        req1_ar_vld = ($urandom_range(0, 2) == 0);
        req1_ar_addr = $urandom; req1_ar_len = 8'($urandom_range(0, 7));
      end
      M_AXI_ARREADY = ($urandom_range(0, 9) < 7);
      req0_r_rdy = ($urandom_range(0, 3) != 0);
      req1_r_rdy = ($urandom_range(0, 3) != 0);
      if (M_AXI_RVALID && m_rhs) begin
        if (M_AXI_RID == 0) begin q0[0]--; if (q0[0] == 0) void'(q0.pop_front()); end
        else                begin q1[0]--; if (q1[0] == 0) void'(q1.pop_front()); end
        M_AXI_RVALID = 0;
      end
      if (!M_AXI_RVALID && (q0.size() > 0 || q1.size() > 0) && $urandom_range(0, 3) != 0) begin
        if (q1.size() == 0 || (q0.size() > 0 && $urandom_range(0, 1) == 0)) begin
          M_AXI_RID = 0; M_AXI_RLAST = (q0[0] == 1);
        end else begin
          M_AXI_RID = 1; M_AXI_RLAST = (q1[0] == 1);
        end
        M_AXI_RDATA = {$urandom, $urandom, $urandom, $urandom};
        M_AXI_RVALID = 1;
      end
      if (c >= 2800) begin
        req0_ar_vld = 0; req1_ar_vld = 0; M_AXI_ARREADY = 1; req0_r_rdy = 1; req1_r_rdy = 1;
      end
      step();
    end
    done = 0;
    for (int c = 0; c < 1000 && !done; c++) begin
      if (M_AXI_RVALID && m_rhs) begin
        if (M_AXI_RID == 0) begin q0[0]--; if (q0[0] == 0) void'(q0.pop_front()); end
        else                begin q1[0]--; if (q1[0] == 0) void'(q1.pop_front()); end
        M_AXI_RVALID = 0;
      end
      if (!M_AXI_RVALID && (q0.size() > 0 || q1.size() > 0)) begin
        if (q0.size() > 0) begin M_AXI_RID = 0; M_AXI_RLAST = (q0[0] == 1); end
        else               begin M_AXI_RID = 1; M_AXI_RLAST = (q1[0] == 1); end
        M_AXI_RVALID = 1;
      end
      done = !M_AXI_RVALID && q0.size() == 0 && q1.size() == 0 && !m_slot_v;
      if (!done) step();
    end
    check("rand_drained", done, 1'b1);
    eval();
    check("rand_idle", idle, 1'b1);
    adv();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
